// File: rtl/noc_host_initiator.sv
// noc_host_initiator: host-side initiator for the 3x3 ALU mesh.
// Accepts one request, injects a single flit into tile (0,0), waits for
// the reply (or a timeout) and hands the result back. At most one packet
// is ever in flight.
module noc_host_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_X          = 2,
    parameter int MAX_Y          = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_dst_x,
    input  logic [1:0]  req_dst_y,
    output logic [63:0] host_in_a,
    output logic [63:0] host_in_b,
    output logic [15:0] host_in_ctrl,
    output logic        host_in_valid,
    input  logic [63:0] host_out_a,
    input  logic        host_out_valid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic        stray_rsp,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0]  STATUS_OK       = 2'b00;
    localparam logic [1:0]  STATUS_TIMEOUT  = 2'b01;
    localparam logic [1:0]  STATUS_BAD_DEST = 2'b10;
    localparam logic [1:0]  STATUS_BAD_OP   = 2'b11;
    localparam logic [15:0] TIMER_LAST      = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_timer;
    logic [63:0] r_hostInA;
    logic [63:0] r_hostInB;
    logic [15:0] r_hostInCtrl;
    logic        r_hostInValid;
    logic        r_rspValid;
    logic [63:0] r_rspData;
    logic [1:0]  r_rspStatus;
    logic        r_busy;
    logic        r_strayRsp;
    logic [15:0] r_pktCount;

    logic        w_destBad;
    logic        w_opBad;
    logic [15:0] w_ctrl;

    // Request screening: the destination check takes priority over the opcode check.
    assign w_destBad = (int'(req_dst_x) > MAX_X) || (int'(req_dst_y) > MAX_Y);
    assign w_opBad   = (req_op > 4'd8);
    assign w_ctrl    = {7'd0, 1'b0, req_dst_x, req_dst_y, req_op};

    assign req_ready     = (r_state == ST_IDLE);
    assign host_in_a     = r_hostInA;
    assign host_in_b     = r_hostInB;
    assign host_in_ctrl  = r_hostInCtrl;
    assign host_in_valid = r_hostInValid;
    assign rsp_valid     = r_rspValid;
    assign rsp_data      = r_rspData;
    assign rsp_status    = r_rspStatus;
    assign busy          = r_busy;
    assign stray_rsp     = r_strayRsp;
    assign pkt_count     = r_pktCount;

    // Transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= 16'd0;
            r_hostInA     <= 64'd0;
            r_hostInB     <= 64'd0;
            r_hostInCtrl  <= 16'd0;
            r_hostInValid <= 1'b0;
            r_rspValid    <= 1'b0;
            r_rspData     <= 64'd0;
            r_rspStatus   <= STATUS_OK;
            r_busy        <= 1'b0;
            r_strayRsp    <= 1'b0;
            r_pktCount    <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (host_out_valid) begin
                        r_strayRsp <= 1'b1;
                    end
                    if (req_valid) begin
                        r_busy <= 1'b1;
                        if (w_destBad) begin
                            r_state     <= ST_RESP;
                            r_rspValid  <= 1'b1;
                            r_rspData   <= 64'd0;
                            r_rspStatus <= STATUS_BAD_DEST;
                        end else if (w_opBad) begin
                            r_state     <= ST_RESP;
                            r_rspValid  <= 1'b1;
                            r_rspData   <= 64'd0;
                            r_rspStatus <= STATUS_BAD_OP;
                        end else begin
                            r_state       <= ST_SEND;
                            r_hostInValid <= 1'b1;
                            r_hostInA     <= req_a;
                            r_hostInB     <= req_b;
                            r_hostInCtrl  <= w_ctrl;
                        end
                    end
                end
                ST_SEND: begin
                    r_hostInValid <= 1'b0;
                    r_hostInA     <= 64'd0;
                    r_hostInB     <= 64'd0;
                    r_hostInCtrl  <= 16'd0;
                    if (host_out_valid) begin
                        r_state     <= ST_RESP;
                        r_rspValid  <= 1'b1;
                        r_rspData   <= host_out_a;
                        r_rspStatus <= STATUS_OK;
                    end else begin
                        r_state <= ST_WAIT;
                        r_timer <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    r_timer <= r_timer + 16'd1;
                    if (host_out_valid) begin
                        r_state     <= ST_RESP;
                        r_rspValid  <= 1'b1;
                        r_rspData   <= host_out_a;
                        r_rspStatus <= STATUS_OK;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state     <= ST_RESP;
                        r_rspValid  <= 1'b1;
                        r_rspData   <= 64'd0;
                        r_rspStatus <= STATUS_TIMEOUT;
                    end
                end
                ST_RESP: begin
                    if (host_out_valid) begin
                        r_strayRsp <= 1'b1;
                    end
                    if (rsp_ready) begin
                        r_state    <= ST_IDLE;
                        r_rspValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_pktCount <= r_pktCount + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
